// File: rtl/seg_scan_driver_if.sv
// Signal bundle between the ring-counter/display-control side and the 7-segment scan driver.
// The master modport is the driving side; the slave modport is the scan driver.
interface seg_scan_driver_if;
  logic [3:0]  digit_sel;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  blink_en;
  logic        busy;
  logic        frame_start;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output digit_sel, data_in, dp_in, load, blank_lz, blink_en,
    input  busy, frame_start, an, seg, dp
  );

  modport slave (
    input  digit_sel, data_in, dp_in, load, blank_lz, blink_en,
    output busy, frame_start, an, seg, dp
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered value and frame-aligned commit.
// Also handles leading-zero blanking, per-digit blink and blanking on an illegal select.
module seg_scan_driver #(
  parameter int unsigned BLINK_HALF = 31
) (
  input  logic             clk_500hz,
  input  logic             reset_n,
  seg_scan_driver_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DP_W   = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DP_W-1:0]  SEL_D3     = 4'b0111;
  localparam logic [DP_W-1:0]  SEL_D2     = 4'b1011;
  localparam logic [DP_W-1:0]  SEL_D1     = 4'b1101;
  localparam logic [DP_W-1:0]  SEL_D0     = 4'b1110;
  localparam logic [SEG_W-1:0] SEG_OFF    = 7'b1111111;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DP_W-1:0]   dp;
  } frame_t;

  frame_t             pend_q, pend_d;
  frame_t             disp_q, disp_d;
  logic               pend_v_q, pend_v_d;
  logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [DP_W-1:0]    an_q, an_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               frame_start_q, frame_start_d;

  logic               frame_edge;
  logic               sel_legal;
  logic [1:0]         idx;
  logic [3:0]         nib;
  logic               lz_blank;
  logic               blink_blank;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] h);
    logic [SEG_W-1:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Buffering, blink timing and per-digit output; outputs use the post-commit
  // display and phase so a whole frame always shows one consistent value.
  always_comb begin
    pend_d        = pend_q;
    pend_v_d      = pend_v_q;
    disp_d        = disp_q;
    blink_cnt_d   = blink_cnt_q;
    blink_ph_d    = blink_ph_q;
    sel_legal     = 1'b1;
    idx           = 2'd0;
    lz_blank      = 1'b0;

    frame_edge = (bus.digit_sel == SEL_D3);

    if (frame_edge && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (bus.load) begin
      pend_d   = '{data: bus.data_in, dp: bus.dp_in};
      pend_v_d = 1'b1;
    end

    if (frame_edge) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end

    case (bus.digit_sel)
      SEL_D3:  idx = 2'd3;
      SEL_D2:  idx = 2'd2;
      SEL_D1:  idx = 2'd1;
      SEL_D0:  idx = 2'd0;
      default: sel_legal = 1'b0;
    endcase

    nib = disp_d.data[{idx, 2'b00} +: 4];
    case (idx)
      2'd3:    lz_blank = (disp_d.data[15:12] == 4'h0);
      2'd2:    lz_blank = (disp_d.data[15:8]  == 8'h00);
      2'd1:    lz_blank = (disp_d.data[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
    lz_blank    = lz_blank && bus.blank_lz;
    blink_blank = bus.blink_en[idx] && blink_ph_d;

    an_d          = sel_legal ? bus.digit_sel : 4'b1111;
    seg_d         = (!sel_legal || lz_blank || blink_blank) ? SEG_OFF : hex_to_seg(nib);
    dp_d          = !(sel_legal && !blink_blank && disp_d.dp[idx]);
    frame_start_d = frame_edge;
  end

  always_ff @(posedge clk_500hz or negedge reset_n) begin
    if (!reset_n) begin
      pend_q        <= '0;
      pend_v_q      <= 1'b0;
      disp_q        <= '0;
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      pend_v_q      <= pend_v_d;
      disp_q        <= disp_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_ph_q    <= blink_ph_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.busy        = pend_v_q;
  assign bus.frame_start = frame_start_q;
  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: reset, decode, blanking, buffering, blink and illegal selects.
module tb_seg_scan_driver;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  localparam logic [3:0] SCAN [4]    = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0] ILLEGAL [4] = '{4'b1111, 4'b0101, 4'b0000, 4'b0011};
  localparam logic [6:0] OFF         = 7'b1111111;

  seg_scan_driver_if bus();

  seg_scan_driver #(.BLINK_HALF(2)) dut (
    .clk_500hz (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h5: return 7'b0100100;
      4'h8: return 7'b0000000;
      4'hA: return 7'b0001000;
      4'hF: return 7'b0111000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic tick(input logic [3:0] sel, input logic ld, input logic [15:0] d, input logic [3:0] p);
    bus.digit_sel = sel;
    bus.load      = ld;
    bus.data_in   = d;
    bus.dp_in     = p;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(SCAN[c % 4], (c == 2), 16'h1234, 4'hF);
      n_tests++;
      if (bus.an !== 4'b1111 || bus.seg !== OFF || bus.dp !== 1'b1 || bus.busy !== 1'b0 || bus.frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d: an=%b seg=%b dp=%b busy=%b fs=%b, want an=1111 seg=1111111 dp=1 busy=0 fs=0",
                 c, bus.an, bus.seg, bus.dp, bus.busy, bus.frame_start);
      end
    end
    rst_n = 1'b1;
    tick(4'b1110, 1'b0, 16'h0, 4'h0);
    n_tests++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b0000001 || bus.dp !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_digit: an=%b seg=%b dp=%b busy=%b, want an=1110 seg=0000001 dp=1 busy=0",
               bus.an, bus.seg, bus.dp, bus.busy);
    end
  endtask

  task automatic test_decode();
    logic [6:0] es [4];
    logic       ed [4];
    es = '{glyph(4'h1), glyph(4'hA), glyph(4'h3), glyph(4'hF)};
    ed = '{1'b1, 1'b1, 1'b0, 1'b1};
    tick(4'b1101, 1'b1, 16'h1A3F, 4'b0010);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL decode_busy_set: busy=%b, want 1", bus.busy);
    end
    for (int k = 0; k < 4; k++) begin
      tick(SCAN[k], 1'b0, 16'h0, 4'h0);
      n_tests++;
      if (bus.an !== SCAN[k] || bus.seg !== es[k] || bus.dp !== ed[k] || bus.frame_start !== (k == 0) || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL decode k=%0d: an=%b seg=%b dp=%b fs=%b busy=%b, want an=%b seg=%b dp=%b fs=%b busy=0",
                 k, bus.an, bus.seg, bus.dp, bus.frame_start, bus.busy, SCAN[k], es[k], ed[k], (k == 0));
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [3];
    logic [3:0]  dps  [3];
    logic [6:0]  es   [3][4];
    logic        ed   [3][4];
    vals = '{16'h0008, 16'h0105, 16'h0000};
    dps  = '{4'b0100, 4'b0000, 4'b0000};
    es   = '{'{OFF, OFF, OFF, glyph(4'h8)},
             '{OFF, glyph(4'h1), glyph(4'h0), glyph(4'h5)},
             '{OFF, OFF, OFF, glyph(4'h0)}};
    ed   = '{'{1'b1, 1'b0, 1'b1, 1'b1},
             '{1'b1, 1'b1, 1'b1, 1'b1},
             '{1'b1, 1'b1, 1'b1, 1'b1}};
    bus.blank_lz = 1'b1;
    for (int v = 0; v < 3; v++) begin
      tick(4'b1101, 1'b1, vals[v], dps[v]);
      for (int k = 0; k < 4; k++) begin
        tick(SCAN[k], 1'b0, 16'h0, 4'h0);
        n_tests++;
        if (bus.an !== SCAN[k] || bus.seg !== es[v][k] || bus.dp !== ed[v][k]) begin
          n_fail++;
          $display("FAIL lz v=%h k=%0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   vals[v], k, bus.an, bus.seg, bus.dp, SCAN[k], es[v][k], ed[v][k]);
        end
      end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    tick(4'b1011, 1'b1, 16'h1111, 4'h0);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_1111: busy=%b, want 1", bus.busy); end
    tick(4'b1101, 1'b1, 16'h2222, 4'h0);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_2222: busy=%b, want 1", bus.busy); end
    tick(4'b1110, 1'b0, 16'h0, 4'h0);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.seg !== glyph(4'h0)) begin
      n_fail++;
      $display("FAIL b2b_pre_frame: busy=%b seg=%b, want busy=1 seg=0000001", bus.busy, bus.seg);
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        tick(SCAN[k], (f == 0 && k == 0), 16'h3333, 4'h0);
        n_tests++;
        if (bus.an !== SCAN[k] || bus.seg !== glyph(f == 0 ? 4'h2 : 4'h3) || bus.busy !== (f == 0)) begin
          n_fail++;
          $display("FAIL b2b f=%0d k=%0d: an=%b seg=%b busy=%b, want an=%b seg=%b busy=%b",
                   f, k, bus.an, bus.seg, bus.busy, SCAN[k], glyph(f == 0 ? 4'h2 : 4'h3), (f == 0));
        end
      end
    end
  endtask

  task automatic test_blink();
    logic ph;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.blink_en = 4'b0001;
    tick(4'b1110, 1'b1, 16'h8888, 4'b0001);
    for (int f = 1; f <= 6; f++) begin
      ph = 1'((f >> 1) & 1);
      for (int k = 0; k < 4; k++) begin
        tick(SCAN[k], 1'b0, 16'h0, 4'h0);
        n_tests++;
        if (bus.an !== SCAN[k] || bus.seg !== ((k == 3 && ph) ? OFF : glyph(4'h8)) || bus.dp !== !(k == 3 && !ph)) begin
          n_fail++;
          $display("FAIL blink f=%0d k=%0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   f, k, bus.an, bus.seg, bus.dp, SCAN[k], (k == 3 && ph) ? OFF : glyph(4'h8), !(k == 3 && !ph));
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic ph;
    for (int i = 0; i < 4; i++) begin
      tick(ILLEGAL[i], 1'b0, 16'h0, 4'h0);
      n_tests++;
      if (bus.an !== 4'b1111 || bus.seg !== OFF || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal sel=%b: an=%b seg=%b dp=%b fs=%b, want an=1111 seg=1111111 dp=1 fs=0",
                 ILLEGAL[i], bus.an, bus.seg, bus.dp, bus.frame_start);
      end
    end
    for (int f = 7; f <= 10; f++) begin
      ph = 1'((f >> 1) & 1);
      for (int k = 0; k < 4; k++) begin
        tick(SCAN[k], 1'b0, 16'h0, 4'h0);
        n_tests++;
        if (bus.an !== SCAN[k] || bus.frame_start !== (k == 0) ||
            bus.seg !== ((k == 3 && ph) ? OFF : glyph(4'h8))) begin
          n_fail++;
          $display("FAIL illegal_resume f=%0d k=%0d: an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                   f, k, bus.an, bus.seg, bus.frame_start, SCAN[k], (k == 3 && ph) ? OFF : glyph(4'h8), (k == 0));
        end
      end
    end
    bus.blink_en = 4'b0000;
  endtask

  task automatic test_reset_mid();
    tick(4'b1011, 1'b1, 16'h4567, 4'hF);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: busy=%b, want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.an !== 4'b1111 || bus.seg !== OFF || bus.dp !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: an=%b seg=%b dp=%b busy=%b, want an=1111 seg=1111111 dp=1 busy=0",
               bus.an, bus.seg, bus.dp, bus.busy);
    end
    tick(4'b0111, 1'b0, 16'h0, 4'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(SCAN[k], 1'b0, 16'h0, 4'h0);
      n_tests++;
      if (bus.an !== SCAN[k] || bus.seg !== glyph(4'h0) || bus.dp !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_after k=%0d: an=%b seg=%b dp=%b busy=%b, want an=%b seg=0000001 dp=1 busy=0",
                 k, bus.an, bus.seg, bus.dp, bus.busy, SCAN[k]);
      end
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.digit_sel = 4'b1111;
    bus.data_in   = 16'h0;
    bus.dp_in     = 4'h0;
    bus.load      = 1'b0;
    bus.blank_lz  = 1'b0;
    bus.blink_en  = 4'h0;
    test_reset();
    test_decode();
    test_leading_zero();
    test_back_to_back();
    test_blink();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Downstream consumer of the 4-bit active-low ring counter in the display path. Takes the rotating digit select, a 16-bit hex value and per-digit decimal points, and drives the multiplexed 7-segment display (anodes, segments, dp). The display value is double-buffered so updates apply only at frame boundaries, which prevents tearing. The block also handles leading-zero blanking, per-digit blink, and blanking on an illegal select.

## Interface
- BLINK_HALF, 31: frames per blink half-period. Range 1–255. At 500 Hz, 4 cycles per frame gives about 0.25 s.
- clk_500hz  in  1  scan clock, same clock as the ring counter
- reset_n  in  1  asynchronous, active-low reset
- digit_sel  in  4  active-low one-hot select from the ring counter. 0111 = digit 3 (leftmost); 1011 = digit 2; 1101 = digit 1; 1110 = digit 0.
- data_in  in  16  hex value. [15:12] = digit 3 … [3:0] = digit 0.
- dp_in  in  4  decimal point request, active-high, bit i = digit i
- load  in  1  single-cycle request to capture data_in and dp_in
- blank_lz  in  1  enable leading-zero blanking
- blink_en  in  4  per-digit blink enable
- busy  out  1  a captured value is pending and not yet displayed
- frame_start  out  1  one-cycle pulse, coincident with an == 0111
- an  out  4  anode drive, active-low
- seg  out  7  {a,b,c,d,e,f,g}, active-low
- dp  out  1  decimal point, active-low

## Operation
- Registers:
  - pending: 16-bit data + 4-bit dp, with valid flag pend_v.
  - display: 16-bit data + 4-bit dp.
  - blink_cnt: 8-bit counter.
  - blink_ph: 1-bit phase.
- Load capture:
  - load=1 writes data_in/dp_in into pending and sets pend_v.
  - A load while pend_v=1 overwrites pending; the latest value wins.
  - busy = pend_v.
- Commit: on an edge where digit_sel==0111 and pend_v was already 1 before that edge:
  - pending copies into display and pend_v clears.
  - If load is also asserted on that edge, the old pending commits and the new value becomes pending (pend_v stays 1).
- Blink timing, advanced on each edge with digit_sel==0111:
  - blink_cnt increments.
  - When blink_cnt==BLINK_HALF-1, blink_cnt wraps to 0 and blink_ph toggles.
- Digit selection: digit_sel maps to index i per the table above. Any other pattern (0000, 1111, multi-hot) is illegal.
- Per-digit output, computed from the display register:
  - Hex decode (active-low segments): 0=0000001, 1=1001111, 3=0000110, 8=0000000, A=0001000, F=0111000; the full 0–F set uses the standard glyphs with b/d lowercase.
  - Leading-zero blanking, when blank_lz=1: digit i (for i = 3..1) is blanked when its nibble and all higher nibbles are 0. Digit 0 is never blanked by this rule.
  - Blink: digit i is blanked when blink_en[i]=1 and blink_ph=1. The dp is blanked too.
  - A blanked digit drives seg=1111111. Under leading-zero blanking, dp still follows dp_in.
- Illegal select drives an=1111, seg=1111111, dp=1, and frame_start=0 for that cycle. It does not affect blink or commit.

## Timing
- an, seg, dp and frame_start are registered with 1-cycle latency from digit_sel. an equals digit_sel delayed one cycle, so anode and segments are always aligned.
- Reset (asynchronous assert, synchronous-safe release) sets:
  - an=1111, seg=1111111, dp=1, frame_start=0, busy=0
  - display=0, dp reg=0, pend_v=0, blink_cnt=0, blink_ph=0
- Commit latency depends on where the load lands:
  - A load on any edge before the next 0111-edge is visible on the first an==0111 frame following that edge.
  - Worst case is a load on the 0111-edge itself: the value commits 4 cycles later and is shown one cycle after that.
- busy asserts on the edge after load and deasserts on the commit edge.
- Reset mid-operation discards pending data and returns to the reset state immediately. The first frame after release starts at whatever digit_sel presents.

## Test plan
- Reset with digit_sel cycling. Expected: an=1111, seg=1111111, dp=1, busy=0. The first legal select after release shows digit 0 of value 0 as seg=0000001.
- Load 16'h1A3F, dp_in=0010, blank_lz=0. Expected over one frame: an=0111/seg=1001111, then 1011/0001000, then 1101/0000110 with dp=0, then 1110/0111000.
- Load 16'h0008 with blank_lz=1. Expected: digits 3..1 show seg=1111111 and digit 0 shows 0000000. Load 16'h0000: digit 0 shows 0000001.
- Two loads mid-frame (16'h1111 then 16'h2222), plus a third load 16'h3333 on the 0111-edge. Expected: busy stays 1 across the sequence. 2222 is displayed in the next frame and 3333 in the frame after; 1111 is never shown.
- blink_en=0001, BLINK_HALF=2. Expected: digit 0 alternates visible/blank every 2 frames (8 cycles), and other digits are unaffected.
- digit_sel=1111, then 0101. Expected: an=1111, seg=1111111, no frame_start. Afterwards the normal scan resumes with blink_cnt unchanged.
